// File: rtl/solution_reader.sv
// rtl/solution_reader.sv - reads a solved 8-queens board row by row and streams column indices
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   start      pulse: board registers hold a complete solution (accepted in IDLE only)
//   out_last   selected board row from the datapath mux, bit k = queen in column k
//   sel        row select driven to the datapath mux
//   busy       high in every state except IDLE
//   col_data   encoded column index of the current row
//   row_idx    row number of the current col_data
//   col_valid  col_data/row_idx valid
//   col_ready  consumer accepts the current beat
//   col_last   high with the beat for the final row
//   done       one-cycle pulse after the final beat is accepted
//   row_err    sticky flag: a captured row was not exactly one-hot
//   sol_count  saturating count of fully delivered solutions

module solution_reader #(
    parameter int ROWS  = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:ROWS-1]  out_last,
    output logic [IDX_W-1:0] sel,
    output logic             busy,
    output logic [IDX_W-1:0] col_data,
    output logic [IDX_W-1:0] row_idx,
    output logic             col_valid,
    input  logic             col_ready,
    output logic             col_last,
    output logic             done,
    output logic             row_err,
    output logic [CNT_W-1:0] sol_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS - 1);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] row_buf [ROWS];

    // Row encoder: position of the set bit plus a population count so that
    // empty or multi-queen rows can be flagged and stored as column 0.
    logic [IDX_W-1:0] enc_idx;
    logic [IDX_W:0]   enc_cnt;
    logic             one_hot;

    always_comb begin
        enc_idx = '0;
        enc_cnt = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (out_last[k]) begin
                enc_idx = IDX_W'(k);
                enc_cnt = enc_cnt + (IDX_W+1)'(1);
            end
        end
        one_hot = (enc_cnt == (IDX_W+1)'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_READ;
            S_READ: if (sel == LAST) state_nx = S_SEND;
            S_SEND: if (col_ready && (ptr == LAST)) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode; col_valid depends on state only, never on col_ready.
    always_comb begin
        busy      = (state != S_IDLE);
        col_valid = (state == S_SEND);
        col_last  = (state == S_SEND) && (ptr == LAST);
        done      = (state == S_DONE);
    end

    assign col_data = row_buf[ptr];
    assign row_idx  = ptr;

    // Datapath: capture, replay pointer, error flag, solution counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel       <= '0;
            ptr       <= '0;
            row_err   <= 1'b0;
            sol_count <= '0;
            for (int i = 0; i < ROWS; i++) begin
                row_buf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel     <= '0;
                        ptr     <= '0;
                        row_err <= 1'b0;
                    end
                end
                S_READ: begin
                    row_buf[sel] <= one_hot ? enc_idx : '0;
                    if (!one_hot) begin
                        row_err <= 1'b1;
                    end
                    sel <= (sel == LAST) ? '0 : sel + IDX_W'(1);
                end
                S_SEND: begin
                    if (col_ready) begin
                        ptr <= (ptr == LAST) ? '0 : ptr + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (sol_count != {CNT_W{1'b1}}) begin
                        sol_count <= sol_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
